// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory-access stage.
// The master drives the EX/MEM bundle and the stall/flush controls; the slave is the stage itself.
interface mem_wb_stage_if;
  logic [31:0] i_result;
  logic [31:0] i_store_data;
  logic [4:0]  i_write_reg;
  logic [1:0]  i_M_control;
  logic [1:0]  i_WB_control;
  logic        i_stall;
  logic        i_flush;
  logic [4:0]  o_write_reg;
  logic [31:0] o_write_data;
  logic [31:0] o_result;
  logic [1:0]  o_WB_control;
  logic [31:0] o_fwd_data;
  logic        o_misaligned;
  logic [7:0]  o_err_count;

  modport master (
    output i_result, i_store_data, i_write_reg, i_M_control, i_WB_control, i_stall, i_flush,
    input  o_write_reg, o_write_data, o_result, o_WB_control, o_fwd_data, o_misaligned, o_err_count
  );

  modport slave (
    input  i_result, i_store_data, i_write_reg, i_M_control, i_WB_control, i_stall, i_flush,
    output o_write_reg, o_write_data, o_result, o_WB_control, o_fwd_data, o_misaligned, o_err_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage with the MEM/WB register over a word-addressed data memory; 1-cycle latency,
// forwarding value is combinational. Stall holds the register, flush bubbles it; both block stores.
module mem_wb_stage #(
  parameter int ADDR_W = 6
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mem_wb_stage_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              mem_read;
  logic              mem_write;
  logic              mis;
  logic              accept;
  logic              mem_we;
  logic [31:0]       rd_data;

  logic [4:0]  write_reg_q;
  logic [31:0] write_data_q;
  logic [31:0] result_q;
  logic [1:0]  wb_control_q;
  logic        misaligned_q;
  logic [7:0]  err_count_q;

  // Upper address bits are dropped, so out-of-range addresses wrap into the array.
  assign idx       = bus.i_result[ADDR_W+1:2];
  assign mem_read  = bus.i_M_control[1];
  assign mem_write = bus.i_M_control[0];
  assign mis       = (mem_read | mem_write) & (bus.i_result[1:0] != 2'b00);
  assign accept    = ~bus.i_stall & ~bus.i_flush;
  assign mem_we    = mem_write & ~mis & accept;
  assign rd_data   = (mem_read & ~mis) ? mem[idx] : 32'd0;

  assign bus.o_fwd_data = mem_read ? rd_data : bus.i_result;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (mem_we) begin
      mem[idx] <= bus.i_store_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      result_q     <= 32'd0;
      wb_control_q <= 2'b00;
    end else if (bus.i_flush) begin
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      result_q     <= 32'd0;
      wb_control_q <= 2'b00;
    end else if (!bus.i_stall) begin
      write_reg_q  <= bus.i_write_reg;
      write_data_q <= rd_data;
      result_q     <= bus.i_result;
      // A misaligned access must never reach the register file.
      wb_control_q <= {bus.i_WB_control[1], bus.i_WB_control[0] & ~mis};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      misaligned_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      misaligned_q <= mis & accept;
      if (mis && accept && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.o_write_reg  = write_reg_q;
  assign bus.o_write_data = write_data_q;
  assign bus.o_result     = result_q;
  assign bus.o_WB_control = wb_control_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_err_count  = err_count_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic against an array-based model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.ADDR_W(6)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state: model memory and predicted registered outputs.
  logic [31:0] mdl [64];
  logic [4:0]  e_wr;
  logic [31:0] e_wd, e_res, e_fwd, obs_fwd;
  logic [1:0]  e_wb;
  logic        e_mis;
  int          e_cnt;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
    e_wr = 5'd0; e_wd = 32'd0; e_res = 32'd0; e_wb = 2'b00; e_mis = 1'b0; e_cnt = 0;
  endtask

  // Drive one instruction for one clock and advance the model; called 1 time unit after an edge.
  task automatic cycle(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] wr,
                       input logic [1:0] m, input logic [1:0] wbc, input logic st, input logic fl);
    int          idx;
    bit          mis;
    logic [31:0] rd;
    bus.i_result = res; bus.i_store_data = sd; bus.i_write_reg = wr;
    bus.i_M_control = m; bus.i_WB_control = wbc; bus.i_stall = st; bus.i_flush = fl;
    idx   = int'((res >> 2) % 32'd64);
    mis   = (m != 2'b00) && (res % 32'd4 != 32'd0);
    rd    = (m[1] && !mis) ? mdl[idx] : 32'd0;
    e_fwd = m[1] ? rd : res;
    #2;
    obs_fwd = bus.o_fwd_data;
    @(posedge clk);
    #1;
    if (fl) begin
      e_wr = 5'd0; e_wd = 32'd0; e_res = 32'd0; e_wb = 2'b00;
    end else if (!st) begin
      e_wr = wr; e_wd = rd; e_res = res; e_wb = {wbc[1], wbc[0] & !mis};
    end
    e_mis = mis && !st && !fl;
    if (e_mis && e_cnt < 255) e_cnt++;
    if (m[0] && !mis && !st && !fl) mdl[idx] = sd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_result = 0; bus.i_store_data = 0; bus.i_write_reg = 0;
    bus.i_M_control = 0; bus.i_WB_control = 0; bus.i_stall = 0; bus.i_flush = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    total_cnt++; if ({bus.o_write_reg, bus.o_write_data, bus.o_result, bus.o_WB_control} !== 71'd0)
      $display("FAIL reset_regs got %h want 0", {bus.o_write_reg, bus.o_write_data, bus.o_result, bus.o_WB_control}); else pass_cnt++;
    total_cnt++; if ({bus.o_misaligned, bus.o_err_count} !== 9'd0)
      $display("FAIL reset_err got %h want 0", {bus.o_misaligned, bus.o_err_count}); else pass_cnt++;
    cycle(32'h10, 32'd0, 5'd1, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (bus.o_write_data !== 32'd0) $display("FAIL reset_load_data got %h want 0", bus.o_write_data); else pass_cnt++;
    total_cnt++; if (bus.o_WB_control !== 2'b11) $display("FAIL reset_load_wb got %b want 11", bus.o_WB_control); else pass_cnt++;
  endtask

  task automatic test_store_load();
    cycle(32'h24, 32'hDEADBEEF, 5'd3, 2'b01, 2'b00, 1'b0, 1'b0);
    cycle(32'h24, 32'd0, 5'd9, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (obs_fwd !== 32'hDEADBEEF) $display("FAIL st_ld_fwd got %h want deadbeef", obs_fwd); else pass_cnt++;
    total_cnt++; if (bus.o_write_data !== 32'hDEADBEEF) $display("FAIL st_ld_data got %h want deadbeef", bus.o_write_data); else pass_cnt++;
    total_cnt++; if (bus.o_result !== 32'h24) $display("FAIL st_ld_result got %h want 24", bus.o_result); else pass_cnt++;
    total_cnt++; if (bus.o_write_reg !== 5'd9) $display("FAIL st_ld_reg got %0d want 9", bus.o_write_reg); else pass_cnt++;
    // Non-memory instruction forwards the ALU result.
    cycle(32'h1234_5673, 32'd0, 5'd2, 2'b00, 2'b01, 1'b0, 1'b0);
    total_cnt++; if (obs_fwd !== 32'h1234_5673) $display("FAIL alu_fwd got %h want 12345673", obs_fwd); else pass_cnt++;
  endtask

  task automatic test_alias();
    cycle(32'h108, 32'h12345678, 5'd4, 2'b01, 2'b00, 1'b0, 1'b0);
    cycle(32'h08, 32'd0, 5'd5, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (bus.o_write_data !== 32'h12345678) $display("FAIL alias_data got %h want 12345678", bus.o_write_data); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    cycle(32'h26, 32'd0, 5'd6, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (bus.o_write_data !== 32'd0) $display("FAIL mis_data got %h want 0", bus.o_write_data); else pass_cnt++;
    total_cnt++; if (bus.o_WB_control[0] !== 1'b0) $display("FAIL mis_regwrite got %b want 0", bus.o_WB_control[0]); else pass_cnt++;
    total_cnt++; if (bus.o_misaligned !== 1'b1) $display("FAIL mis_pulse got %b want 1", bus.o_misaligned); else pass_cnt++;
    total_cnt++; if (bus.o_err_count !== 8'd1) $display("FAIL mis_count got %0d want 1", bus.o_err_count); else pass_cnt++;
    cycle(32'h0, 32'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    total_cnt++; if (bus.o_misaligned !== 1'b0) $display("FAIL mis_pulse_end got %b want 0", bus.o_misaligned); else pass_cnt++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) cycle(32'h26, 32'd0, 5'd6, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (bus.o_err_count !== 8'hFF) $display("FAIL sat_count got %0d want 255", bus.o_err_count); else pass_cnt++;
    total_cnt++; if (bus.o_misaligned !== 1'b1) $display("FAIL sat_pulse got %b want 1", bus.o_misaligned); else pass_cnt++;
  endtask

  task automatic test_stall();
    cycle(32'h30, 32'd0, 5'd7, 2'b10, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(32'h40, 32'hA5A5A5A5, 5'd4, 2'b01, 2'b00, 1'b1, 1'b0);
      total_cnt++; if (bus.o_result !== 32'h30 || bus.o_write_reg !== 5'd7 || bus.o_WB_control !== 2'b11)
        $display("FAIL stall_hold%0d got %h/%0d/%b want 30/7/11", i, bus.o_result, bus.o_write_reg, bus.o_WB_control); else pass_cnt++;
    end
    cycle(32'h40, 32'd0, 5'd2, 2'b10, 2'b11, 1'b1, 1'b0);
    total_cnt++; if (obs_fwd !== 32'd0) $display("FAIL stall_nowrite got %h want 0", obs_fwd); else pass_cnt++;
    cycle(32'h40, 32'hA5A5A5A5, 5'd4, 2'b01, 2'b00, 1'b0, 1'b0);
    cycle(32'h40, 32'd0, 5'd8, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (bus.o_write_data !== 32'hA5A5A5A5) $display("FAIL stall_commit got %h want a5a5a5a5", bus.o_write_data); else pass_cnt++;
  endtask

  task automatic test_flush();
    cycle(32'h44, 32'h1, 5'd5, 2'b01, 2'b01, 1'b1, 1'b1);
    total_cnt++; if ({bus.o_write_reg, bus.o_write_data, bus.o_result, bus.o_WB_control} !== 71'd0)
      $display("FAIL flush_bubble got %h want 0", {bus.o_write_reg, bus.o_write_data, bus.o_result, bus.o_WB_control}); else pass_cnt++;
    cycle(32'h44, 32'd0, 5'd5, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (bus.o_write_data !== 32'd0) $display("FAIL flush_nowrite got %h want 0", bus.o_write_data); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    cycle(32'h24, 32'd0, 5'd9, 2'b10, 2'b11, 1'b0, 1'b0);
    bus.i_result = 32'h24; bus.i_store_data = 32'h55; bus.i_M_control = 2'b01;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({bus.o_write_reg, bus.o_write_data, bus.o_result, bus.o_WB_control} !== 71'd0)
      $display("FAIL async_rst_regs got %h want 0", {bus.o_write_reg, bus.o_write_data, bus.o_result, bus.o_WB_control}); else pass_cnt++;
    total_cnt++; if ({bus.o_misaligned, bus.o_err_count} !== 9'd0)
      $display("FAIL async_rst_err got %h want 0", {bus.o_misaligned, bus.o_err_count}); else pass_cnt++;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(32'h24, 32'd0, 5'd9, 2'b10, 2'b11, 1'b0, 1'b0);
    total_cnt++; if (bus.o_write_data !== 32'd0) $display("FAIL async_rst_mem got %h want 0", bus.o_write_data); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] res;
    logic [1:0]  lo;
    for (int n = 0; n < 400; n++) begin
      lo  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      res = ($urandom_range(0, 3) == 0 ? ($urandom & 32'hFFFF_FF00) : 32'd0)
            | (32'($urandom_range(0, 15)) << 2) | {30'd0, lo};
      cycle(res, $urandom, 5'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      total_cnt++; if (obs_fwd !== e_fwd) $display("FAIL rnd_fwd[%0d] got %h want %h", n, obs_fwd, e_fwd); else pass_cnt++;
      total_cnt++; if (bus.o_write_data !== e_wd) $display("FAIL rnd_data[%0d] got %h want %h", n, bus.o_write_data, e_wd); else pass_cnt++;
      total_cnt++; if (bus.o_result !== e_res) $display("FAIL rnd_result[%0d] got %h want %h", n, bus.o_result, e_res); else pass_cnt++;
      total_cnt++; if (bus.o_write_reg !== e_wr) $display("FAIL rnd_reg[%0d] got %0d want %0d", n, bus.o_write_reg, e_wr); else pass_cnt++;
      total_cnt++; if (bus.o_WB_control !== e_wb) $display("FAIL rnd_wb[%0d] got %b want %b", n, bus.o_WB_control, e_wb); else pass_cnt++;
      total_cnt++; if (bus.o_misaligned !== e_mis) $display("FAIL rnd_mis[%0d] got %b want %b", n, bus.o_misaligned, e_mis); else pass_cnt++;
      total_cnt++; if (bus.o_err_count !== 8'(e_cnt)) $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, bus.o_err_count, e_cnt); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_misaligned();
    test_saturate();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d of %0d checks", pass_cnt, total_cnt);
    $fatal(1);
  end
endmodule
